// File: rtl/tof_echo_timer.sv
// Time-of-flight shot controller: fires a transmit pulse, blanks the receiver for a guard
// window, then counts enabled cycles until the first clean rising edge of the returning echo.
module tof_echo_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int PULSE_LEN = 4,
    parameter int GUARD     = 2,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 start,
    input  logic                 echo_in,
    output logic                 tx_pulse,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] tof_count,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TX_LAST     = CNT_WIDTH'(PULSE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] BLANK_LAST  = CNT_WIDTH'(PULSE_LEN + GUARD - 1);
    localparam logic [CNT_WIDTH-1:0] LISTEN_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] tof_q;
    logic                 echo_prev_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 timeout_q;
    logic                 echo_edge;

    assign cnt_d     = cnt_q + 1'b1;
    // Edges are judged only between consecutive enabled samples of echo_in.
    assign echo_edge = echo_in & ~echo_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tof_q       <= '0;
            echo_prev_q <= 1'b0;
            tx_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (we && state_q != S_REPORT) begin
                echo_prev_q <= echo_in;
            end
            case (state_q)
                S_IDLE: begin
                    if (we && start) begin
                        state_q <= S_TX;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b1;
                    end
                end
                S_TX: begin
                    if (we) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == TX_LAST) begin
                            tx_q    <= 1'b0;
                            state_q <= (GUARD == 0) ? S_LISTEN : S_BLANK;
                        end
                    end
                end
                S_BLANK: begin
                    if (we) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= S_LISTEN;
                        end
                    end
                end
                S_LISTEN: begin
                    // An echo edge on the final listening cycle still counts as a capture.
                    if (we) begin
                        if (echo_edge) begin
                            tof_q   <= cnt_q;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_REPORT;
                        end else if (cnt_q == LISTEN_LAST) begin
                            tof_q     <= '1;
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_REPORT;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_REPORT: begin
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_pulse    = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign tof_count   = tof_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tof_echo_timer.sv
// Bench for tof_echo_timer: directed and randomized shots checked against a sample-indexed model.
module tb_tof_echo_timer;

    localparam int CW = 16;
    localparam int PL = 4;
    localparam int GD = 2;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic          start = 1'b0;
    logic          echo_in = 1'b0;
    logic          tx_pulse;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] tof_count;
    logic [2:0]    dbg_state;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic          echo_s [0:TO];
    logic [CW-1:0] prev_tof = '0;

    always #5 clk = ~clk;

    tof_echo_timer #(
        .CNT_WIDTH(CW),
        .PULSE_LEN(PL),
        .GUARD    (GD),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .start      (start),
        .echo_in    (echo_in),
        .tx_pulse   (tx_pulse),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .tof_count  (tof_count),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic s, input logic e, input logic r);
        @(negedge clk);
        we      = w;
        start   = s;
        echo_in = e;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rise(input int at);
        for (int k = 0; k <= TO; k++) echo_s[k] = (k >= at);
    endtask

    // we_mode: 0 = always enabled, 1 = alternating 0/1, 2 = random.
    task automatic run_shot(input int we_mode, input int abort_at, input bit poke_start);
        int            k_end;
        logic          exp_to;
        logic [CW-1:0] exp_tof;
        int            e;
        bit            fin;
        logic          w;
        logic          ev;
        k_end   = TO - 1;
        exp_to  = 1'b1;
        exp_tof = '1;
        // First rising sample inside the listening window, else timeout at the last one.
        for (int k = PL + GD; k <= TO - 1; k++) begin
            if (echo_s[k] && !echo_s[k-1]) begin
                k_end   = k;
                exp_to  = 1'b0;
                exp_tof = CW'(k);
                break;
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("launch_tx", tx_pulse, 1);
        check("launch_busy", busy, 1);
        check("launch_done", done, 0);
        check("launch_tof", tof_count, prev_tof);
        e   = 0;
        fin = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            case (we_mode)
                0:       w = 1'b1;
                1:       w = (cyc % 2 == 1);
                default: w = 1'($urandom_range(0, 1));
            endcase
            if (w && abort_at >= 0 && e == abort_at) begin
                step(1'b1, 1'b0, 1'b1, 1'b1);
                check("rst_busy", busy, 0);
                check("rst_tx", tx_pulse, 0);
                check("rst_done", done, 0);
                check("rst_timeout", timeout, 0);
                check("rst_tof", tof_count, 0);
                prev_tof = '0;
                step(1'b1, 1'b0, 1'b0, 1'b0);
                check("post_rst_busy", busy, 0);
                return;
            end
            ev = w ? echo_s[e] : 1'($urandom_range(0, 1));
            step(w, poke_start && (e > PL + GD), ev, 1'b0);
            if (w && e == k_end) begin
                check("end_done", done, 1);
                check("end_timeout", timeout, exp_to);
                check("end_tof", tof_count, exp_tof);
                check("end_busy", busy, 0);
                check("end_tx", tx_pulse, 0);
                fin = 1;
            end else begin
                if (w) e++;
                check("run_tx", tx_pulse, (e < PL));
                check("run_busy", busy, 1);
                check("run_done", done, 0);
                check("run_timeout", timeout, 0);
                check("run_tof", tof_count, prev_tof);
            end
        end
        check("shot_finished", fin, 1);
        prev_tof = exp_tof;
        step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("report_done", done, 0);
        check("report_timeout", timeout, 0);
        check("report_busy", busy, 0);
        check("report_tx", tx_pulse, 0);
        check("report_tof", tof_count, prev_tof);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_busy", busy, 0);
        check("idle_tx", tx_pulse, 0);
    endtask

    initial begin
        int r;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_tx", tx_pulse, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_timeout", timeout, 0);
        check("reset_tof", tof_count, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_disabled_start", busy, 0);

        set_rise(20);
        run_shot(0, -1, 0);

        set_rise(3);
        run_shot(0, -1, 0);

        for (int k = 0; k <= TO; k++) echo_s[k] = ((k >= 3) && (k < 7)) || (k >= 30);
        run_shot(0, -1, 0);

        set_rise(20);
        run_shot(1, -1, 0);

        set_rise(99);
        run_shot(0, -1, 1);

        set_rise(TO + 5);
        run_shot(0, 50, 0);
        set_rise(12);
        run_shot(0, -1, 0);

        for (int s = 0; s < 6; s++) begin
            r = $urandom_range(0, TO + 10);
            for (int k = 0; k <= TO; k++) echo_s[k] = (k >= r) ? 1'b1 : ($urandom_range(0, 9) == 0);
            run_shot(2, -1, s % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
